// File: rtl/smac_pkg.sv
// Shared types and width helpers for the serial MAC slice sequencer.
package smac_pkg;

  localparam int unsigned PIPE_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic valid;
    logic i_first;
    logic i_last;
    logic j_first;
    logic j_msb;
  } tag_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit cfg_ok(input int unsigned m, input int unsigned pa,
                                input int unsigned pw);
    return (m >= 1) && (pa >= 2) && (pw >= 2);
  endfunction

endpackage

// File: rtl/smac_tag_pipe.sv
// Shift register of per-plane tags; stage k is the tag issued k+1 cycles earlier.
module smac_tag_pipe
  import smac_pkg::*;
#(
  parameter int unsigned DEPTH = PIPE_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  tag_t tag_in,
  output tag_t stage [DEPTH],
  output logic empty_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  always_comb begin
    empty_c = 1'b1;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (stage[k].valid) empty_c = 1'b0;
    end
  end

endmodule

// File: rtl/smac_seq_ctrl.sv
// Control sequencer for one serial MAC slice: walks activation/weight bit-planes
// MSB first and issues pipelined datapath enables from a tag shift register.
module smac_seq_ctrl
  import smac_pkg::*;
#(
  parameter int unsigned M  = 64,
  parameter int unsigned Pa = 8,
  parameter int unsigned Pw = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic                  abort,
  output logic [idx_w(Pa)-1:0]  act_idx,
  output logic [idx_w(Pw)-1:0]  wei_idx,
  output logic                  we_a,
  output logic                  we_w,
  output logic                  MSB_a,
  output logic                  we_br,
  output logic                  we_ac1,
  output logic                  cl_en_ac1,
  output logic                  we_neg,
  output logic                  MSB_w,
  output logic                  we_ac2,
  output logic                  cl_en_ac2,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam int unsigned AW     = idx_w(Pa);
  localparam int unsigned WW     = idx_w(Pw);
  localparam logic [AW-1:0] I_TOP = AW'(Pa - 1);
  localparam logic [WW-1:0] J_TOP = WW'(Pw - 1);
  localparam bit            CFG_OK = cfg_ok(M, Pa, Pw);

  state_e        state;
  logic [AW-1:0] i_cnt;
  logic [WW-1:0] j_cnt;
  tag_t          tag_in;
  tag_t          stage [PIPE_DEPTH];
  logic          pipe_empty_c;
  logic          issue_c;
  logic          accept_c;
  logic          unused_tag_c;

  // An illegal parameter set never accepts a job.
  assign issue_c  = (state == RUN) && !abort;
  assign accept_c = (state == IDLE) && job_valid && !abort && CFG_OK;

  always_comb begin
    tag_in         = '0;
    tag_in.valid   = issue_c;
    tag_in.i_first = (i_cnt == I_TOP);
    tag_in.i_last  = (i_cnt == '0);
    tag_in.j_first = (j_cnt == J_TOP);
    tag_in.j_msb   = (j_cnt == J_TOP);
  end

  smac_tag_pipe #(.DEPTH(PIPE_DEPTH)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort),
    .tag_in  (tag_in),
    .stage   (stage),
    .empty_c (pipe_empty_c)
  );

  assign unused_tag_c = ^{stage[0].i_last, stage[0].j_first, stage[0].j_msb,
                          stage[1].i_last, stage[1].j_first, stage[1].j_msb,
                          stage[2].i_first, stage[2].j_first,
                          stage[3].i_first, stage[3].j_msb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i_cnt     <= '0;
      j_cnt     <= '0;
      job_ready <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      act_idx   <= '0;
      wei_idx   <= '0;
      we_a      <= 1'b0;
      we_w      <= 1'b0;
      MSB_a     <= 1'b0;
      we_br     <= 1'b0;
      we_ac1    <= 1'b0;
      cl_en_ac1 <= 1'b0;
      we_neg    <= 1'b0;
      MSB_w     <= 1'b0;
      we_ac2    <= 1'b0;
      cl_en_ac2 <= 1'b0;
    end else begin
      // Issue stage: weight reg only reloads on the first plane of a group.
      we_a    <= issue_c;
      we_w    <= issue_c && (i_cnt == I_TOP);
      act_idx <= issue_c ? i_cnt : '0;
      wei_idx <= issue_c ? j_cnt : '0;

      // Each downstream enable decodes a single tag stage.
      we_br     <= !abort && stage[0].valid;
      MSB_a     <= !abort && stage[0].valid && stage[0].i_first;
      we_ac1    <= !abort && stage[1].valid;
      cl_en_ac1 <= !abort && stage[1].valid && stage[1].i_first;
      we_neg    <= !abort && stage[2].valid && stage[2].i_last;
      MSB_w     <= !abort && stage[2].valid && stage[2].i_last && stage[2].j_msb;
      we_ac2    <= !abort && stage[3].valid && stage[3].i_last;
      cl_en_ac2 <= !abort && stage[3].valid && stage[3].i_last && stage[3].j_first;

      case (state)
        IDLE: begin
          if (accept_c) begin
            state     <= RUN;
            job_ready <= 1'b0;
            busy      <= 1'b1;
            i_cnt     <= I_TOP;
            j_cnt     <= J_TOP;
          end
        end
        RUN: begin
          if (i_cnt == '0) begin
            i_cnt <= I_TOP;
            if (j_cnt == '0) state <= DRAIN;
            else             j_cnt <= j_cnt - 1'b1;
          end else begin
            i_cnt <= i_cnt - 1'b1;
          end
        end
        DRAIN: begin
          if (pipe_empty_c) begin
            state     <= DONE;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            job_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (abort) begin
        state     <= IDLE;
        res_valid <= 1'b0;
        busy      <= 1'b0;
        job_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_smac_seq_ctrl.sv
// Directed bench for smac_seq_ctrl with a behavioural noAC3 datapath model.
module tb_smac_seq_ctrl;

  localparam int LN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default configuration instance
  logic       job_valid, job_ready, abort, res_ready, res_valid, busy;
  logic [2:0] act_idx;
  logic [1:0] wei_idx;
  logic we_a, we_w, MSB_a, we_br, we_ac1, cl_en_ac1, we_neg, MSB_w, we_ac2, cl_en_ac2;
  logic [9:0] en_vec;
  assign en_vec = {we_a, we_w, MSB_a, we_br, we_ac1, cl_en_ac1, we_neg, MSB_w, we_ac2, cl_en_ac2};

  smac_seq_ctrl u_dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .abort(abort),
    .act_idx(act_idx), .wei_idx(wei_idx), .we_a(we_a), .we_w(we_w), .MSB_a(MSB_a),
    .we_br(we_br), .we_ac1(we_ac1), .cl_en_ac1(cl_en_ac1), .we_neg(we_neg), .MSB_w(MSB_w),
    .we_ac2(we_ac2), .cl_en_ac2(cl_en_ac2), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy)
  );

  // Pa=2, Pw=2 instance
  logic       s_job_valid, s_job_ready, s_abort, s_res_ready, s_res_valid, s_busy;
  logic [0:0] s_act_idx, s_wei_idx;
  logic s_we_a, s_we_w, s_MSB_a, s_we_br, s_we_ac1, s_cl_en_ac1, s_we_neg, s_MSB_w, s_we_ac2, s_cl_en_ac2;
  logic [9:0] s_en_vec;
  assign s_en_vec = {s_we_a, s_we_w, s_MSB_a, s_we_br, s_we_ac1, s_cl_en_ac1, s_we_neg,
                     s_MSB_w, s_we_ac2, s_cl_en_ac2};

  smac_seq_ctrl #(.M(64), .Pa(2), .Pw(2)) u_small (
    .clk(clk), .rst(rst), .job_valid(s_job_valid), .job_ready(s_job_ready), .abort(s_abort),
    .act_idx(s_act_idx), .wei_idx(s_wei_idx), .we_a(s_we_a), .we_w(s_we_w), .MSB_a(s_MSB_a),
    .we_br(s_we_br), .we_ac1(s_we_ac1), .cl_en_ac1(s_cl_en_ac1), .we_neg(s_we_neg),
    .MSB_w(s_MSB_w), .we_ac2(s_we_ac2), .cl_en_ac2(s_cl_en_ac2), .res_valid(s_res_valid),
    .res_ready(s_res_ready), .busy(s_busy)
  );

  // Datapath model driven by the default instance's enables
  logic [7:0]    a_op [LN];
  logic [3:0]    w_op [LN];
  logic [LN-1:0] m_areg, m_wreg;
  int            m_br, m_ac1, m_neg, m_ac2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_areg <= '0; m_wreg <= '0;
      m_br <= 0; m_ac1 <= 0; m_neg <= 0; m_ac2 <= 0;
    end else begin
      for (int l = 0; l < LN; l++) begin
        if (we_a) m_areg[l] <= a_op[l][act_idx];
        if (we_w) m_wreg[l] <= w_op[l][wei_idx];
      end
      if (we_br)  m_br  <= MSB_a ? -$countones(m_areg & m_wreg) : $countones(m_areg & m_wreg);
      if (we_ac1) m_ac1 <= cl_en_ac1 ? m_br : 2 * m_ac1 + m_br;
      if (we_neg) m_neg <= MSB_w ? -m_ac1 : m_ac1;
      if (we_ac2) m_ac2 <= cl_en_ac2 ? m_neg : 2 * m_ac2 + m_neg;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int ref_dot();
    int s = 0;
    for (int l = 0; l < LN; l++) s += int'($signed(a_op[l])) * int'($signed(w_op[l]));
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job();
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic run_dp_job(input int expected, input string name);
    start_job();
    for (int k = 0; k < 60 && !res_valid; k++) tick();
    n_cmp++;
    if (res_valid !== 1'b1) begin
      n_bad++; $display("FAIL %s timeout res_valid=%b required=1", name, res_valid);
    end
    n_cmp++;
    if (m_ac2 !== expected) begin
      n_bad++; $display("FAIL %s out_ac2=%0d required=%0d", name, m_ac2, expected);
    end
    tick();
  endtask

  task automatic test_reset();
    tick();
    n_cmp++;
    if ({job_ready, busy, res_valid, en_vec} !== {3'b100, 10'h0}) begin
      n_bad++; $display("FAIL reset_held got=%h required=%h", {job_ready, busy, res_valid, en_vec}, {3'b100, 10'h0});
    end
    @(negedge clk) rst = 1'b0;
    tick();
    n_cmp++;
    if ({job_ready, busy, res_valid, en_vec, act_idx, wei_idx} !== {3'b100, 15'h0}) begin
      n_bad++; $display("FAIL reset_release got=%h required=%h", {job_ready, busy, res_valid, en_vec, act_idx, wei_idx}, {3'b100, 15'h0});
    end
  endtask

  task automatic test_timing_default();
    logic [9:0] exp;
    int wa = 0;
    res_ready = 1'b1;
    start_job();
    for (int c = 1; c <= 40; c++) begin
      tick();
      exp[9] = (c <= 32);
      exp[8] = c inside {1, 9, 17, 25};
      exp[7] = c inside {2, 10, 18, 26};
      exp[6] = (c >= 2 && c <= 33);
      exp[5] = (c >= 3 && c <= 34);
      exp[4] = c inside {3, 11, 19, 27};
      exp[3] = c inside {11, 19, 27, 35};
      exp[2] = (c == 11);
      exp[1] = c inside {12, 20, 28, 36};
      exp[0] = (c == 12);
      if (we_a) wa++;
      n_cmp++;
      if (en_vec !== exp) begin
        n_bad++; $display("FAIL dflt_enables cyc=%0d got=%b required=%b", c, en_vec, exp);
      end
      n_cmp++;
      if ({res_valid, job_ready} !== {(c == 37), (c >= 38)}) begin
        n_bad++; $display("FAIL dflt_handshake cyc=%0d got=%b required=%b", c, {res_valid, job_ready}, {(c == 37), (c >= 38)});
      end
      if (c <= 32) begin
        n_cmp++;
        if ({act_idx, wei_idx} !== {3'(7 - (c - 1) % 8), 2'(3 - (c - 1) / 8)}) begin
          n_bad++; $display("FAIL dflt_idx cyc=%0d got=%h required=%h", c, {act_idx, wei_idx}, {3'(7 - (c - 1) % 8), 2'(3 - (c - 1) / 8)});
        end
      end
    end
    n_cmp++;
    if (wa !== 32) begin
      n_bad++; $display("FAIL dflt_we_a_count got=%0d required=32", wa);
    end
  endtask

  task automatic test_small_cfg();
    logic [9:0] exp;
    logic [1:0] idx_exp [4];
    idx_exp[0] = 2'b11; idx_exp[1] = 2'b01; idx_exp[2] = 2'b10; idx_exp[3] = 2'b00;
    s_res_ready = 1'b1;
    s_job_valid = 1'b1;
    tick();
    s_job_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      exp[9] = (c <= 4);
      exp[8] = c inside {1, 3};
      exp[7] = c inside {2, 4};
      exp[6] = (c >= 2 && c <= 5);
      exp[5] = (c >= 3 && c <= 6);
      exp[4] = c inside {3, 5};
      exp[3] = c inside {5, 7};
      exp[2] = (c == 5);
      exp[1] = c inside {6, 8};
      exp[0] = (c == 6);
      n_cmp++;
      if (s_en_vec !== exp) begin
        n_bad++; $display("FAIL small_enables cyc=%0d got=%b required=%b", c, s_en_vec, exp);
      end
      n_cmp++;
      if ({s_res_valid, s_job_ready} !== {(c == 9), (c >= 10)}) begin
        n_bad++; $display("FAIL small_handshake cyc=%0d got=%b required=%b", c, {s_res_valid, s_job_ready}, {(c == 9), (c >= 10)});
      end
      if (c <= 4) begin
        n_cmp++;
        if ({s_act_idx, s_wei_idx} !== idx_exp[c-1]) begin
          n_bad++; $display("FAIL small_idx cyc=%0d got=%b required=%b", c, {s_act_idx, s_wei_idx}, idx_exp[c-1]);
        end
      end
    end
  endtask

  task automatic test_datapath();
    res_ready = 1'b1;
    for (int l = 0; l < LN; l++) begin a_op[l] = 8'hFF; w_op[l] = 4'b0011; end
    run_dp_job(-192, "dp_ones_x3");
    for (int l = 0; l < LN; l++) begin a_op[l] = 8'h80; w_op[l] = 4'h8; end
    run_dp_job(65536, "dp_min_x_min");
    for (int l = 0; l < LN; l++) begin a_op[l] = 8'h7F; w_op[l] = 4'h8; end
    run_dp_job(-65024, "dp_max_x_min");
    for (int n = 0; n < 100; n++) begin
      for (int l = 0; l < LN; l++) begin a_op[l] = 8'($urandom); w_op[l] = 4'($urandom); end
      run_dp_job(ref_dot(), "dp_random");
    end
  endtask

  task automatic test_hold();
    int exp_dot;
    for (int l = 0; l < LN; l++) begin a_op[l] = 8'($urandom); w_op[l] = 4'($urandom); end
    exp_dot = ref_dot();
    res_ready = 1'b0;
    start_job();
    for (int k = 0; k < 60 && !res_valid; k++) tick();
    job_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if ({res_valid, busy, job_ready, en_vec} !== {3'b110, 10'h0}) begin
        n_bad++; $display("FAIL hold_state k=%0d got=%h required=%h", k, {res_valid, busy, job_ready, en_vec}, {3'b110, 10'h0});
      end
    end
    job_valid = 1'b0;
    n_cmp++;
    if (m_ac2 !== exp_dot) begin
      n_bad++; $display("FAIL hold_result out_ac2=%0d required=%0d", m_ac2, exp_dot);
    end
    res_ready = 1'b1;
    tick();
    n_cmp++;
    if ({res_valid, busy, job_ready} !== 3'b001) begin
      n_bad++; $display("FAIL hold_ack got=%b required=001", {res_valid, busy, job_ready});
    end
    tick();
    n_cmp++;
    if ({busy, job_ready, en_vec} !== {2'b01, 10'h0}) begin
      n_bad++; $display("FAIL hold_ignored_job got=%h required=%h", {busy, job_ready, en_vec}, {2'b01, 10'h0});
    end
  endtask

  task automatic test_abort();
    res_ready = 1'b1;
    start_job();
    repeat (5) tick();
    n_cmp++;
    if ({we_a, act_idx, wei_idx} !== {1'b1, 3'd3, 2'd3}) begin
      n_bad++; $display("FAIL abort_issue5 got=%b required=%b", {we_a, act_idx, wei_idx}, {1'b1, 3'd3, 2'd3});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({job_ready, busy, res_valid, en_vec} !== {3'b100, 10'h0}) begin
      n_bad++; $display("FAIL abort_next got=%h required=%h", {job_ready, busy, res_valid, en_vec}, {3'b100, 10'h0});
    end
    for (int k = 0; k < 45; k++) begin
      tick();
      n_cmp++;
      if ({res_valid, en_vec} !== 11'h0) begin
        n_bad++; $display("FAIL abort_quiet k=%0d got=%h required=0", k, {res_valid, en_vec});
      end
    end
    job_valid = 1'b1;
    abort = 1'b1;
    tick();
    job_valid = 1'b0;
    abort = 1'b0;
    tick();
    n_cmp++;
    if ({job_ready, busy, en_vec} !== {2'b10, 10'h0}) begin
      n_bad++; $display("FAIL abort_with_job got=%h required=%h", {job_ready, busy, en_vec}, {2'b10, 10'h0});
    end
    for (int l = 0; l < LN; l++) begin a_op[l] = 8'($urandom); w_op[l] = 4'($urandom); end
    run_dp_job(ref_dot(), "abort_recover");
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b1;
    start_job();
    repeat (34) tick();
    n_cmp++;
    if ({busy, we_a, we_ac1} !== 3'b101) begin
      n_bad++; $display("FAIL rst_mid_drain got=%b required=101", {busy, we_a, we_ac1});
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({job_ready, busy, res_valid, en_vec} !== {3'b100, 10'h0}) begin
      n_bad++; $display("FAIL rst_mid_async got=%h required=%h", {job_ready, busy, res_valid, en_vec}, {3'b100, 10'h0});
    end
    tick();
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if ({job_ready, busy, res_valid, en_vec} !== {3'b100, 10'h0}) begin
        n_bad++; $display("FAIL rst_mid_after k=%0d got=%h required=%h", k, {job_ready, busy, res_valid, en_vec}, {3'b100, 10'h0});
      end
    end
  endtask

  initial begin
    job_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    s_job_valid = 1'b0; s_abort = 1'b0; s_res_ready = 1'b0;
    for (int l = 0; l < LN; l++) begin a_op[l] = '0; w_op[l] = '0; end
    test_reset();
    test_timing_default();
    test_small_cfg();
    test_datapath();
    test_hold();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
